// File: rtl/ctrl_pkg.sv
// Shared types for the 8-bit sequencer: opcodes, sequencer states and the
// packed control word that drives the datapath.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDI = 3'd1,
    OP_LD  = 3'd2,
    OP_ST  = 3'd3,
    OP_ALU = 3'd4,
    OP_JMP = 3'd5,
    OP_JCC = 3'd6,
    OP_HLT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_E0   = 3'd2,
    ST_E1   = 3'd3,
    ST_E2   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  typedef struct packed {
    logic       alu_oe;
    logic       alu_sub_shift_dir;
    logic       alu_b_wr;
    logic [1:0] alu_op;
    logic       reg_wr0;
    logic       reg_wr1;
    logic       reg_bus_sel;
    logic       reg_bus_en;
    logic       alu_sel;
    logic       ram_address_en;
    logic       ram_write_en;
    logic       ram_oe;
    logic       ram_read_data_select;
    logic       load_pc;
    logic       incr_pc;
    logic       pc_oe;
  } ctrl_word_t;

  function automatic opcode_e ir_opcode(input logic [7:0] ir);
    return opcode_e'(ir[7:5]);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational micro-sequence decoder: (state, IR, flags) -> control word
// and next state.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic [7:0] i_ir,
  input  logic       i_flag_n,
  input  logic       i_flag_z,
  output ctrl_word_t o_ctrl,
  output state_e     o_next
);

  opcode_e op_s;
  logic    rd_s;
  logic    rs_s;
  logic    taken_s;

  assign op_s    = ir_opcode(i_ir);
  assign rd_s    = i_ir[4];
  assign rs_s    = i_ir[3];
  assign taken_s = i_ir[0] ? i_flag_z : i_flag_n;

  // Per-state, per-opcode control word and sequencing
  always_comb begin
    o_ctrl = '0;
    o_next = i_state;
    case (i_state)
      ST_F0: begin
        o_ctrl.pc_oe          = 1'b1;
        o_ctrl.ram_address_en = 1'b1;
        o_next                = ST_F1;
      end
      ST_F1: begin
        o_ctrl.ram_oe  = 1'b1;
        o_ctrl.incr_pc = 1'b1;
        o_next         = ST_E0;
      end
      ST_E0: begin
        case (op_s)
          OP_NOP: o_next = ST_F0;
          OP_HLT: o_next = ST_HALT;
          OP_ALU: begin
            o_ctrl.reg_bus_sel = rs_s;
            o_ctrl.reg_bus_en  = 1'b1;
            o_ctrl.alu_b_wr    = 1'b1;
            o_next             = ST_E1;
          end
          OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JCC: begin
            o_ctrl.pc_oe          = 1'b1;
            o_ctrl.ram_address_en = 1'b1;
            o_next                = ST_E1;
          end
          default: o_next = ST_F0;
        endcase
      end
      ST_E1: begin
        o_next = ST_F0;
        case (op_s)
          OP_LDI: begin
            o_ctrl.ram_oe  = 1'b1;
            o_ctrl.incr_pc = 1'b1;
            if (rd_s) o_ctrl.reg_wr1 = 1'b1;
            else      o_ctrl.reg_wr0 = 1'b1;
          end
          // Second byte is the RAM address; latch it and move to E2
          OP_LD, OP_ST: begin
            o_ctrl.ram_oe         = 1'b1;
            o_ctrl.ram_address_en = 1'b1;
            o_ctrl.incr_pc        = 1'b1;
            o_next                = ST_E2;
          end
          OP_ALU: begin
            o_ctrl.alu_sel           = rd_s;
            o_ctrl.alu_op            = i_ir[2:1];
            o_ctrl.alu_sub_shift_dir = i_ir[0];
            o_ctrl.alu_oe            = 1'b1;
            if (rd_s) o_ctrl.reg_wr1 = 1'b1;
            else      o_ctrl.reg_wr0 = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.ram_oe  = 1'b1;
            o_ctrl.load_pc = 1'b1;
          end
          OP_JCC: begin
            if (taken_s) begin
              o_ctrl.ram_oe  = 1'b1;
              o_ctrl.load_pc = 1'b1;
            end else begin
              o_ctrl.incr_pc = 1'b1;
            end
          end
          default: o_next = ST_F0;
        endcase
      end
      ST_E2: begin
        o_next = ST_F0;
        case (op_s)
          OP_LD: begin
            o_ctrl.ram_oe = 1'b1;
            if (rd_s) o_ctrl.reg_wr1 = 1'b1;
            else      o_ctrl.reg_wr0 = 1'b1;
          end
          OP_ST: begin
            o_ctrl.reg_bus_sel  = rs_s;
            o_ctrl.reg_bus_en   = 1'b1;
            o_ctrl.ram_write_en = 1'b1;
          end
          default: o_next = ST_F0;
        endcase
      end
      ST_HALT: o_next = ST_HALT;
      default: o_next = ST_F0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit datapath: holds state and IR, and
// gates the decoded control word with step-enable and reset.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stepEn,
  input  logic [7:0] i_bus,
  input  logic       i_aluFlagN,
  input  logic       i_aluFlagZ,
  output logic       o_ctrlAluOE,
  output logic       o_ctrlAluSubShiftDir,
  output logic       o_ctrlAluBWr,
  output logic [1:0] o_ctrlAluOp,
  output logic       o_ctrlRegWr0,
  output logic       o_ctrlRegWr1,
  output logic       o_ctrlRegBusSel,
  output logic       o_ctrlRegBusEn,
  output logic       o_ctrlAluSel,
  output logic       o_ctrlRamAddressEn,
  output logic       o_ctrlRamWriteEn,
  output logic       o_ctrlRamOE,
  output logic       o_ctrlRamReadDataSelect,
  output logic       o_ctrlLoadPC,
  output logic       o_ctrlIncrPC,
  output logic       o_ctrlPCOe,
  output logic       o_halted,
  output logic [7:0] o_ir
);

  state_e     state_q, state_d, next_state_s;
  logic [7:0] ir_q, ir_d;
  ctrl_word_t dec_ctrl_s, ctrl_s;

  ctrl_decode u_decode (
    .i_state  (state_q),
    .i_ir     (ir_q),
    .i_flag_n (i_aluFlagN),
    .i_flag_z (i_aluFlagZ),
    .o_ctrl   (dec_ctrl_s),
    .o_next   (next_state_s)
  );

  // Advance only when stepping; IR captures the bus at the end of F1
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    if (i_stepEn) begin
      state_d = next_state_s;
      if (state_q == ST_F1) ir_d = i_bus;
      else                  ir_d = ir_q;
    end else begin
      state_d = state_q;
    end
  end

  // State and instruction register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_F0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs drop to zero while frozen or in reset, even mid-cycle
  always_comb begin
    ctrl_s = '0;
    if (i_stepEn && !i_reset) ctrl_s = dec_ctrl_s;
    else                      ctrl_s = '0;
  end

  assign o_ctrlAluOE             = ctrl_s.alu_oe;
  assign o_ctrlAluSubShiftDir    = ctrl_s.alu_sub_shift_dir;
  assign o_ctrlAluBWr            = ctrl_s.alu_b_wr;
  assign o_ctrlAluOp             = ctrl_s.alu_op;
  assign o_ctrlRegWr0            = ctrl_s.reg_wr0;
  assign o_ctrlRegWr1            = ctrl_s.reg_wr1;
  assign o_ctrlRegBusSel         = ctrl_s.reg_bus_sel;
  assign o_ctrlRegBusEn          = ctrl_s.reg_bus_en;
  assign o_ctrlAluSel            = ctrl_s.alu_sel;
  assign o_ctrlRamAddressEn      = ctrl_s.ram_address_en;
  assign o_ctrlRamWriteEn        = ctrl_s.ram_write_en;
  assign o_ctrlRamOE             = ctrl_s.ram_oe;
  assign o_ctrlRamReadDataSelect = ctrl_s.ram_read_data_select;
  assign o_ctrlLoadPC            = ctrl_s.load_pc;
  assign o_ctrlIncrPC            = ctrl_s.incr_pc;
  assign o_ctrlPCOe              = ctrl_s.pc_oe;
  assign o_halted                = (state_q == ST_HALT);
  assign o_ir                    = ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: per-cycle expectations go into a
// scoreboard queue and a negedge monitor pops and compares them.
module tb_control_unit;

  logic       i_clk = 1'b0;
  logic       i_reset, i_stepEn, i_aluFlagN, i_aluFlagZ;
  logic [7:0] i_bus;
  logic       o_ctrlAluOE, o_ctrlAluSubShiftDir, o_ctrlAluBWr;
  logic [1:0] o_ctrlAluOp;
  logic       o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel;
  logic       o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamOE, o_ctrlRamReadDataSelect;
  logic       o_ctrlLoadPC, o_ctrlIncrPC, o_ctrlPCOe, o_halted;
  logic [7:0] o_ir;

  localparam logic [16:0] M_AOE   = 17'h10000;
  localparam logic [16:0] M_SUB   = 17'h08000;
  localparam logic [16:0] M_BWR   = 17'h04000;
  localparam logic [16:0] M_OP3   = 17'h03000;
  localparam logic [16:0] M_WR0   = 17'h00800;
  localparam logic [16:0] M_WR1   = 17'h00400;
  localparam logic [16:0] M_BSEL  = 17'h00200;
  localparam logic [16:0] M_BEN   = 17'h00100;
  localparam logic [16:0] M_ASEL  = 17'h00080;
  localparam logic [16:0] M_ADDR  = 17'h00040;
  localparam logic [16:0] M_WE    = 17'h00020;
  localparam logic [16:0] M_ROE   = 17'h00010;
  localparam logic [16:0] M_LPC   = 17'h00004;
  localparam logic [16:0] M_INC   = 17'h00002;
  localparam logic [16:0] M_PCOE  = 17'h00001;
  localparam logic [16:0] FETCH   = M_PCOE | M_ADDR;
  localparam logic [16:0] NONE    = 17'h00000;

  int errors = 0;
  int checks = 0;

  logic [25:0] exp_q[$];
  string       name_q[$];
  logic [16:0] obs_ctrl;

  assign obs_ctrl = {o_ctrlAluOE, o_ctrlAluSubShiftDir, o_ctrlAluBWr, o_ctrlAluOp,
                     o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn,
                     o_ctrlAluSel, o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamOE,
                     o_ctrlRamReadDataSelect, o_ctrlLoadPC, o_ctrlIncrPC, o_ctrlPCOe};

  control_unit dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stepEn(i_stepEn), .i_bus(i_bus),
    .i_aluFlagN(i_aluFlagN), .i_aluFlagZ(i_aluFlagZ),
    .o_ctrlAluOE(o_ctrlAluOE), .o_ctrlAluSubShiftDir(o_ctrlAluSubShiftDir),
    .o_ctrlAluBWr(o_ctrlAluBWr), .o_ctrlAluOp(o_ctrlAluOp),
    .o_ctrlRegWr0(o_ctrlRegWr0), .o_ctrlRegWr1(o_ctrlRegWr1),
    .o_ctrlRegBusSel(o_ctrlRegBusSel), .o_ctrlRegBusEn(o_ctrlRegBusEn),
    .o_ctrlAluSel(o_ctrlAluSel), .o_ctrlRamAddressEn(o_ctrlRamAddressEn),
    .o_ctrlRamWriteEn(o_ctrlRamWriteEn), .o_ctrlRamOE(o_ctrlRamOE),
    .o_ctrlRamReadDataSelect(o_ctrlRamReadDataSelect),
    .o_ctrlLoadPC(o_ctrlLoadPC), .o_ctrlIncrPC(o_ctrlIncrPC), .o_ctrlPCOe(o_ctrlPCOe),
    .o_halted(o_halted), .o_ir(o_ir)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs just after the edge and queue its expectation
  task automatic step(input logic rst, input logic en, input logic [7:0] bus,
                      input logic n, input logic z, input logic [16:0] ec,
                      input logic eh, input logic [7:0] eir, input string nm);
    @(posedge i_clk);
    #1;
    i_reset    = rst;
    i_stepEn   = en;
    i_bus      = bus;
    i_aluFlagN = n;
    i_aluFlagZ = z;
    exp_q.push_back({eh, eir, ec});
    name_q.push_back(nm);
  endtask

  // Monitor: mid-cycle compare against the queued expectation
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [25:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({o_halted, o_ir, obs_ctrl} !== e) begin
        errors++;
        $display("FAIL %s: got halted=%b ir=%h ctrl=%h, want halted=%b ir=%h ctrl=%h",
                 nm, o_halted, o_ir, obs_ctrl, e[25], e[24:17], e[16:0]);
      end
      checks++;
      if ($countones({o_ctrlAluOE, o_ctrlRegBusEn, o_ctrlRamOE, o_ctrlPCOe}) > 1) begin
        errors++;
        $display("FAIL %s_bus_overlap: got drivers=%b, want at most one high", nm,
                 {o_ctrlAluOE, o_ctrlRegBusEn, o_ctrlRamOE, o_ctrlPCOe});
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_stepEn = 1'b1; i_bus = 8'h00; i_aluFlagN = 1'b0; i_aluFlagZ = 1'b0;
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, NONE, 1'b0, 8'h00, "reset0");
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, NONE, 1'b0, 8'h00, "reset1");
    // LDI r0,#0x5A with a two-cycle freeze in E0
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                 1'b0, 8'h00, "ldi_f0");
    step(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, M_ROE | M_INC,         1'b0, 8'h00, "ldi_f1");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, NONE,                  1'b0, 8'h20, "ldi_frz0");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, NONE,                  1'b0, 8'h20, "ldi_frz1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                 1'b0, 8'h20, "ldi_e0");
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, M_ROE | M_WR0 | M_INC, 1'b0, 8'h20, "ldi_e1");
    // ALU 0x90: r1 <- r1 op r0
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                   1'b0, 8'h20, "alu90_f0");
    step(1'b0, 1'b1, 8'h90, 1'b0, 1'b0, M_ROE | M_INC,           1'b0, 8'h20, "alu90_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, M_BEN | M_BWR,           1'b0, 8'h90, "alu90_e0");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, M_ASEL | M_AOE | M_WR1,  1'b0, 8'h90, "alu90_e1");
    // ALU 0x97: op=3, sub=1, frozen once in E1
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                   1'b0, 8'h90, "alu97_f0");
    step(1'b0, 1'b1, 8'h97, 1'b0, 1'b0, M_ROE | M_INC,           1'b0, 8'h90, "alu97_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, M_BEN | M_BWR,           1'b0, 8'h97, "alu97_e0");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, NONE,                    1'b0, 8'h97, "alu97_frz");
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, M_ASEL | M_AOE | M_WR1 | M_SUB | M_OP3,
         1'b0, 8'h97, "alu97_e1");
    // ST r1,[0x40]
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                    1'b0, 8'h97, "st_f0");
    step(1'b0, 1'b1, 8'h78, 1'b0, 1'b0, M_ROE | M_INC,            1'b0, 8'h97, "st_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                    1'b0, 8'h78, "st_e0");
    step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, M_ROE | M_ADDR | M_INC,   1'b0, 8'h78, "st_e1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, M_BSEL | M_BEN | M_WE,    1'b0, 8'h78, "st_e2");
    // Jcc Z taken, Z not taken, N taken
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'h78, "jz1_f0");
    step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'h78, "jz1_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hC1, "jz1_e0");
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b1, M_ROE | M_LPC, 1'b0, 8'hC1, "jz1_e1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hC1, "jz0_f0");
    step(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'hC1, "jz0_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, FETCH,         1'b0, 8'hC1, "jz0_e0");
    step(1'b0, 1'b1, 8'h10, 1'b1, 1'b0, M_INC,         1'b0, 8'hC1, "jz0_e1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hC1, "jn_f0");
    step(1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'hC1, "jn_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hC0, "jn_e0");
    step(1'b0, 1'b1, 8'h20, 1'b1, 1'b0, M_ROE | M_LPC, 1'b0, 8'hC0, "jn_e1");
    // JMP then NOP
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hC0, "jmp_f0");
    step(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'hC0, "jmp_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hA0, "jmp_e0");
    step(1'b0, 1'b1, 8'h30, 1'b0, 1'b0, M_ROE | M_LPC, 1'b0, 8'hA0, "jmp_e1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'hA0, "nop_f0");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'hA0, "nop_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, NONE,          1'b0, 8'h00, "nop_e0");
    // LD r1,[imm]
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                  1'b0, 8'h00, "ld_f0");
    step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, M_ROE | M_INC,          1'b0, 8'h00, "ld_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,                  1'b0, 8'h50, "ld_e0");
    step(1'b0, 1'b1, 8'h40, 1'b0, 1'b0, M_ROE | M_ADDR | M_INC, 1'b0, 8'h50, "ld_e1");
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, M_ROE | M_WR1,          1'b0, 8'h50, "ld_e2");
    // LD aborted by reset in E1
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'h50, "ldab_f0");
    step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'h50, "ldab_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'h50, "ldab_e0");
    step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0, NONE,          1'b0, 8'h00, "ldab_rst0");
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, NONE,          1'b0, 8'h00, "ldab_rst1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH,         1'b0, 8'h00, "rel_f0");
    // HLT, then hold in HALT with step-enable toggling
    step(1'b0, 1'b1, 8'hE0, 1'b0, 1'b0, M_ROE | M_INC, 1'b0, 8'h00, "hlt_f1");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, NONE,          1'b0, 8'hE0, "hlt_e0");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 8'hFF, 1'b1, 1'b1, NONE, 1'b1, 8'hE0, "halt_hold");
    end
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, NONE,  1'b0, 8'h00, "halt_rst");
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, FETCH, 1'b0, 8'h00, "post_halt_f0");
    @(negedge i_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
